// File: rtl/cpu_fetch_pkg.sv
// Shared types for the instruction fetch front end: fetch FSM states and buffered fetch entries.
package cpu_fetch_pkg;

  localparam int unsigned FETCH_ADDR_W = 12;
  localparam logic [5:0]  OPC_J        = 6'h02;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    DROP
  } fetch_state_t;

  typedef struct packed {
    logic [FETCH_ADDR_W-1:0] pc;
    logic [31:0]             instr;
  } fetch_entry_t;

  function automatic logic is_jump(input logic [31:0] instr);
    return instr[31:26] == OPC_J;
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO of fetch entries with push/pop, single-cycle flush and a combinational head read.
module fetch_fifo
  import cpu_fetch_pkg::*;
#(
  parameter  int unsigned DEPTH = 4,
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  fetch_entry_t     push_data,
  input  logic             pop,
  input  logic             flush,
  output logic [CNT_W-1:0] count,
  output fetch_entry_t     head
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  fetch_entry_t     mem [DEPTH];
  logic [PTR_W-1:0] wptr;
  logic [PTR_W-1:0] rptr;

  always_ff @(posedge clk) begin
    if (push && !flush) mem[wptr] <= push_data;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) wptr <= wptr + PTR_W'(1);
      if (pop)  rptr <= rptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  assign head = mem[rptr];

endmodule

// File: rtl/instr_fetch_queue.sv
// CPU fetch front end: PC, one-outstanding RAM fetch FSM, entry FIFO and redirect flush.
// Optional J-type predecode redirect of the PC is enabled by INSTR_FETCH_JUMP_PREDECODE_EN.
module instr_fetch_queue
  import cpu_fetch_pkg::*;
#(
  parameter int unsigned       DEPTH    = 4,
  parameter int unsigned       ADDR_W   = FETCH_ADDR_W,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              reset,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_gnt,
  input  logic              mem_rvalid,
  input  logic [31:0]       mem_rdata,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_instr,
  output logic [ADDR_W-1:0] out_pc,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc
);

  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  fetch_state_t      state;
  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] req_pc;
  logic [CNT_W-1:0]  count;
  fetch_entry_t      head;
  fetch_entry_t      push_data;
  logic              push;
  logic              pop;

  assign mem_req   = !reset && (state == IDLE) && (count < CNT_W'(DEPTH)) && !redirect_valid;
  assign mem_addr  = pc;
  assign push      = (state == WAIT) && mem_rvalid && !redirect_valid;
  assign pop       = out_valid && out_ready && !redirect_valid;
  assign push_data = '{pc: FETCH_ADDR_W'(req_pc), instr: mem_rdata};

  assign out_valid = (count != '0);
  assign out_instr = out_valid ? head.instr : '0;
  assign out_pc    = out_valid ? ADDR_W'(head.pc) : '0;

  // Redirect wins over everything; an un-returned request must be drained in DROP.
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      pc     <= RESET_PC;
      req_pc <= '0;
    end else if (redirect_valid) begin
      pc    <= redirect_pc;
      state <= (state != IDLE && !mem_rvalid) ? DROP : IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (mem_req && mem_gnt) begin
            req_pc <= pc;
            pc     <= pc + ADDR_W'(1);
            state  <= WAIT;
          end
        end
        WAIT: begin
          if (mem_rvalid) begin
            state <= IDLE;
`ifdef INSTR_FETCH_JUMP_PREDECODE_EN
            if (is_jump(mem_rdata)) pc <= mem_rdata[ADDR_W-1:0];
`endif
          end
        end
        DROP: begin
          if (mem_rvalid) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .flush     (redirect_valid),
    .count     (count),
    .head      (head)
  );

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Directed self-checking bench for instr_fetch_queue with an optional auto-responding RAM model.
module tb_instr_fetch_queue;

  logic        clk = 1'b0;
  logic        reset;
  logic        mem_req;
  logic [11:0] mem_addr;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [11:0] out_pc;
  logic        redirect_valid;
  logic [11:0] redirect_pc;

  int tests = 0;
  int fails = 0;

  // RAM model: auto mode answers every grant one cycle later with addr+0x100.
  logic        auto_mem;
  logic        a_rvalid;
  logic [31:0] a_rdata;
  logic        m_rvalid;
  logic [31:0] m_rdata;
  logic        pend;
  logic [11:0] paddr;

  assign mem_rvalid = auto_mem ? a_rvalid : m_rvalid;
  assign mem_rdata  = auto_mem ? a_rdata  : m_rdata;

  always #5 clk = ~clk;

  instr_fetch_queue dut (
    .clk            (clk),
    .reset          (reset),
    .mem_req        (mem_req),
    .mem_addr       (mem_addr),
    .mem_gnt        (mem_gnt),
    .mem_rvalid     (mem_rvalid),
    .mem_rdata      (mem_rdata),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_instr      (out_instr),
    .out_pc         (out_pc),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc)
  );

  always @(negedge clk) begin
    if (reset || !auto_mem) begin
      a_rvalid = 1'b0;
      a_rdata  = 32'h0;
      pend     = 1'b0;
      paddr    = 12'h0;
    end else begin
      a_rvalid = pend;
      if (pend) a_rdata = 32'(paddr) + 32'h100;
      pend  = mem_req && mem_gnt;
      paddr = mem_addr;
    end
  end

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    reset = 1'b1; auto_mem = 1'b0; mem_gnt = 1'b0; m_rvalid = 1'b0; m_rdata = 32'h0;
    redirect_valid = 1'b0; redirect_pc = 12'h0; out_ready = 1'b0;
    step;
    step;
  endtask

  task automatic test_reset;
    do_reset;
    #1;
    tests++; if (mem_req !== 1'b0) begin fails++; $display("FAIL reset_mem_req got %b exp 0", mem_req); end
    tests++; if (mem_addr !== 12'h000) begin fails++; $display("FAIL reset_mem_addr got %h exp 000", mem_addr); end
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid got %b exp 0", out_valid); end
    tests++; if (out_instr !== 32'h0) begin fails++; $display("FAIL reset_out_instr got %h exp 0", out_instr); end
    tests++; if (out_pc !== 12'h0) begin fails++; $display("FAIL reset_out_pc got %h exp 0", out_pc); end
    reset = 1'b0;
    #1;
    tests++; if (mem_req !== 1'b1) begin fails++; $display("FAIL post_reset_req got %b exp 1", mem_req); end
  endtask

  task automatic test_stream;
    int n = 0;
    do_reset;
    reset = 1'b0; mem_gnt = 1'b1; out_ready = 1'b1; auto_mem = 1'b1;
    for (int cyc = 0; cyc < 40 && n < 6; cyc++) begin
      @(negedge clk); #2;
      if (out_valid) begin
        tests++;
        if (out_pc !== 12'(n) || out_instr !== 32'(n + 256)) begin
          fails++; $display("FAIL stream_%0d got pc %h instr %h exp pc %h instr %h", n, out_pc, out_instr, 12'(n), 32'(n + 256));
        end
        n++;
      end
    end
    tests++; if (n != 6) begin fails++; $display("FAIL stream_timeout got %0d entries exp 6", n); end
  endtask

  task automatic test_full;
    int n = 1;
    do_reset;
    reset = 1'b0; mem_gnt = 1'b1; out_ready = 1'b0; auto_mem = 1'b1;
    repeat (20) step;
    tests++; if (mem_req !== 1'b0) begin fails++; $display("FAIL full_req got %b exp 0", mem_req); end
    tests++; if (out_pc !== 12'h0 || out_instr !== 32'h100) begin fails++; $display("FAIL full_head got %h/%h exp 000/00000100", out_pc, out_instr); end
    out_ready = 1'b1;
    step;
    out_ready = 1'b0;
    #1;
    tests++; if (mem_req !== 1'b1 || out_pc !== 12'h1) begin fails++; $display("FAIL full_pop_one got req %b pc %h exp req 1 pc 001", mem_req, out_pc); end
    repeat (10) step;
    tests++; if (mem_req !== 1'b0 || out_pc !== 12'h1) begin fails++; $display("FAIL refill got req %b pc %h exp req 0 pc 001", mem_req, out_pc); end
    mem_gnt = 1'b0; out_ready = 1'b1;
    for (int cyc = 0; cyc < 20 && n < 5; cyc++) begin
      @(negedge clk); #2;
      if (out_valid) begin
        tests++;
        if (out_pc !== 12'(n) || out_instr !== 32'(n + 256)) begin
          fails++; $display("FAIL drain_%0d got pc %h instr %h exp pc %h", n, out_pc, out_instr, 12'(n));
        end
        n++;
      end
    end
    tests++; if (n != 5) begin fails++; $display("FAIL drain_count got %0d exp 5", n); end
    @(negedge clk); #2;
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL drain_empty got %b exp 0", out_valid); end
  endtask

  task automatic test_redirect_wait;
    do_reset;
    reset = 1'b0; out_ready = 1'b1; mem_gnt = 1'b1;
    step;
    mem_gnt = 1'b0; redirect_valid = 1'b1; redirect_pc = 12'h040;
    step;
    redirect_valid = 1'b0;
    #1;
    tests++; if (mem_req !== 1'b0 || mem_addr !== 12'h040) begin fails++; $display("FAIL drop_state got req %b addr %h exp req 0 addr 040", mem_req, mem_addr); end
    step;
    m_rvalid = 1'b1; m_rdata = 32'hDEAD;
    step;
    m_rvalid = 1'b0;
    #1;
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL drop_discard got %b exp 0", out_valid); end
    tests++; if (mem_req !== 1'b1 || mem_addr !== 12'h040) begin fails++; $display("FAIL drop_restart got req %b addr %h exp req 1 addr 040", mem_req, mem_addr); end
    mem_gnt = 1'b1;
    step;
    mem_gnt = 1'b0; m_rvalid = 1'b1; m_rdata = 32'h140;
    step;
    m_rvalid = 1'b0;
    #1;
    tests++; if (out_valid !== 1'b1 || out_pc !== 12'h040 || out_instr !== 32'h140) begin
      fails++; $display("FAIL redirect_first got v %b pc %h instr %h exp 1 040 00000140", out_valid, out_pc, out_instr);
    end
  endtask

  task automatic test_redirect_rvalid_pop;
    do_reset;
    reset = 1'b0; mem_gnt = 1'b1;
    step;
    mem_gnt = 1'b0; m_rvalid = 1'b1; m_rdata = 32'h100;
    step;
    m_rvalid = 1'b0; mem_gnt = 1'b1;
    #1;
    tests++; if (out_valid !== 1'b1 || out_pc !== 12'h0) begin fails++; $display("FAIL rr_setup got v %b pc %h exp 1 000", out_valid, out_pc); end
    step;
    mem_gnt = 1'b0; m_rvalid = 1'b1; m_rdata = 32'h101; out_ready = 1'b1;
    redirect_valid = 1'b1; redirect_pc = 12'h080;
    #1;
    tests++; if (mem_req !== 1'b0) begin fails++; $display("FAIL rr_req_during_redirect got %b exp 0", mem_req); end
    step;
    m_rvalid = 1'b0; redirect_valid = 1'b0; out_ready = 1'b0;
    #1;
    tests++; if (out_valid !== 1'b0 || out_pc !== 12'h0 || out_instr !== 32'h0) begin
      fails++; $display("FAIL rr_flush got v %b pc %h instr %h exp 0 000 0", out_valid, out_pc, out_instr);
    end
    tests++; if (mem_req !== 1'b1 || mem_addr !== 12'h080) begin fails++; $display("FAIL rr_restart got req %b addr %h exp 1 080", mem_req, mem_addr); end
    step;
    step;
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL rr_nothing_pushed got %b exp 0", out_valid); end
  endtask

  task automatic test_wrap;
    do_reset;
    reset = 1'b0; redirect_valid = 1'b1; redirect_pc = 12'hFFF;
    step;
    redirect_valid = 1'b0;
    #1;
    tests++; if (mem_addr !== 12'hFFF) begin fails++; $display("FAIL wrap_start got %h exp fff", mem_addr); end
    mem_gnt = 1'b1;
    step;
    mem_gnt = 1'b0;
    #1;
    tests++; if (mem_addr !== 12'h000) begin fails++; $display("FAIL wrap_addr got %h exp 000", mem_addr); end
    m_rvalid = 1'b1; m_rdata = 32'h1234;
    step;
    m_rvalid = 1'b0;
    #1;
    tests++; if (out_pc !== 12'hFFF || out_instr !== 32'h1234) begin fails++; $display("FAIL wrap_entry got %h/%h exp fff/00001234", out_pc, out_instr); end
  endtask

  task automatic test_jump;
    logic [11:0] exp_addr;
`ifdef INSTR_FETCH_JUMP_PREDECODE_EN
    exp_addr = 12'h123;
`else
    exp_addr = 12'h006;
`endif
    do_reset;
    reset = 1'b0; redirect_valid = 1'b1; redirect_pc = 12'h005;
    step;
    redirect_valid = 1'b0; mem_gnt = 1'b1;
    step;
    mem_gnt = 1'b0; m_rvalid = 1'b1; m_rdata = 32'h0800_0123;
    step;
    m_rvalid = 1'b0;
    #1;
    tests++; if (mem_addr !== exp_addr) begin fails++; $display("FAIL jump_next_addr got %h exp %h", mem_addr, exp_addr); end
    tests++; if (out_pc !== 12'h005 || out_instr !== 32'h0800_0123) begin fails++; $display("FAIL jump_entry got %h/%h exp 005/08000123", out_pc, out_instr); end
  endtask

  task automatic test_reset_mid_fetch;
    do_reset;
    reset = 1'b0; mem_gnt = 1'b1; redirect_valid = 1'b1; redirect_pc = 12'h010;
    step;
    redirect_valid = 1'b0;
    step;
    mem_gnt = 1'b0; reset = 1'b1;
    step;
    reset = 1'b0; m_rvalid = 1'b1; m_rdata = 32'hBEEF;
    step;
    m_rvalid = 1'b0;
    #1;
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_abandon got %b exp 0", out_valid); end
    tests++; if (mem_req !== 1'b1 || mem_addr !== 12'h000) begin fails++; $display("FAIL reset_abandon_pc got req %b addr %h exp 1 000", mem_req, mem_addr); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset;
    test_stream;
    test_full;
    test_redirect_wait;
    test_redirect_rvalid_pop;
    test_wrap;
    test_jump;
    test_reset_mid_fetch;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
